// File: rtl/i2s_pkg.sv
// Shared types and defaults for the stereo I2S capture scheduler.
package i2s_pkg;
  localparam int SAMPLE_W           = 16;
  localparam int FRAME_LEN_DEF      = 256;
  localparam int WARMUP_SAMPLES_DEF = 4096;

  typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, DROP} sched_state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  function automatic int buf_addr_w(input int frame_len);
    return $clog2(frame_len) + 1;
  endfunction
endpackage

// File: rtl/i2s_frame_scheduler_if.sv
// Receiver, ping-pong buffer and consumer signals of the frame scheduler.
// FRAME_SCHED_STATS_EN adds the dropped-sample counter output.
interface i2s_frame_scheduler_if
  import i2s_pkg::*;
#(
  parameter int ADDR_W = buf_addr_w(FRAME_LEN_DEF)
);
  logic                  enable_in;
  logic                  mic_reset_out;
  logic                  sample_valid_in;
  logic [SAMPLE_W-1:0]   left_sample_in;
  logic [SAMPLE_W-1:0]   right_sample_in;
  logic                  buf_we_out;
  logic [ADDR_W-1:0]     buf_addr_out;
  logic [2*SAMPLE_W-1:0] buf_wdata_out;
  logic                  frame_ready_out;
  logic                  frame_bank_out;
  logic                  frame_done_in;
  logic                  overflow_out;
`ifdef FRAME_SCHED_STATS_EN
  logic [15:0]           dropped_count_out;
`endif

  // scheduler side
  modport master (
    input  enable_in, sample_valid_in, left_sample_in, right_sample_in, frame_done_in,
`ifdef FRAME_SCHED_STATS_EN
    output dropped_count_out,
`endif
    output mic_reset_out, buf_we_out, buf_addr_out, buf_wdata_out,
           frame_ready_out, frame_bank_out, overflow_out
  );

  modport slave (
    output enable_in, sample_valid_in, left_sample_in, right_sample_in, frame_done_in,
`ifdef FRAME_SCHED_STATS_EN
    input  dropped_count_out,
`endif
    input  mic_reset_out, buf_we_out, buf_addr_out, buf_wdata_out,
           frame_ready_out, frame_bank_out, overflow_out
  );
endinterface

// File: rtl/frame_bank_tracker.sv
// Ownership of the two ping-pong banks and in-order presentation to the consumer.
module frame_bank_tracker (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       clear,
  input  logic       claim,
  input  logic       claim_bank,
  input  logic       rel,
  output logic [1:0] owned,
  output logic       frame_ready,
  output logic       frame_bank
);
  logic       rel_ok;
  logic [1:0] owned_nxt;

  assign rel_ok = rel & frame_ready;

  always_comb begin
    owned_nxt = owned;
    if (rel_ok) owned_nxt[frame_bank] = 1'b0;
    if (claim)  owned_nxt[claim_bank] = 1'b1;
  end

  // Banks are claimed and released in strict alternation, so the presented
  // bank simply flips on every accepted release.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      owned       <= 2'b00;
      frame_ready <= 1'b0;
      frame_bank  <= 1'b0;
    end else if (clear) begin
      owned       <= 2'b00;
      frame_ready <= 1'b0;
      frame_bank  <= 1'b0;
    end else begin
      owned       <= owned_nxt;
      frame_ready <= |owned_nxt;
      if (rel_ok) frame_bank <= ~frame_bank;
    end
  end
endmodule

// File: rtl/i2s_frame_scheduler.sv
// Stereo I2S capture sequencer: warm-up discard, ping-pong frame packing, overflow.
// FRAME_SCHED_STATS_EN adds a saturating dropped_count_out.
module i2s_frame_scheduler
  import i2s_pkg::*;
#(
  parameter int FRAME_LEN      = FRAME_LEN_DEF,
  parameter int WARMUP_SAMPLES = WARMUP_SAMPLES_DEF
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  i2s_frame_scheduler_if.master  bus
);
  localparam int IDX_W   = $clog2(FRAME_LEN);
  localparam int WU_W    = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam int WU_LAST = (WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0;

  sched_state_t     state;
  logic [IDX_W-1:0] idx;
  logic             wbank;
  logic [WU_W-1:0]  wu_cnt;
  logic             claim, claim_bank, clear;
  logic [1:0]       owned, owned_eff;
  stereo_t          smp;

  assign clear = ~bus.enable_in;
  assign smp   = {bus.left_sample_in, bus.right_sample_in};

  // A release in the same cycle wins over a completion check.
  always_comb begin
    owned_eff = owned;
    if (bus.frame_done_in && bus.frame_ready_out) owned_eff[bus.frame_bank_out] = 1'b0;
  end

  frame_bank_tracker u_trk (
    .gclk        (clock_in),
    .grst_n      (reset_n_in),
    .clear       (clear),
    .claim       (claim),
    .claim_bank  (claim_bank),
    .rel         (bus.frame_done_in),
    .owned       (owned),
    .frame_ready (bus.frame_ready_out),
    .frame_bank  (bus.frame_bank_out)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state             <= IDLE;
      bus.mic_reset_out <= 1'b1;
      bus.buf_we_out    <= 1'b0;
      bus.buf_addr_out  <= '0;
      bus.buf_wdata_out <= '0;
      bus.overflow_out  <= 1'b0;
      idx               <= '0;
      wbank             <= 1'b0;
      wu_cnt            <= '0;
      claim             <= 1'b0;
      claim_bank        <= 1'b0;
    end else begin
      bus.buf_we_out <= 1'b0;
      claim          <= 1'b0;
      if (!bus.enable_in) begin
        state             <= IDLE;
        bus.mic_reset_out <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state             <= (WARMUP_SAMPLES == 0) ? CAPTURE : WARMUP;
            bus.mic_reset_out <= 1'b0;
            bus.overflow_out  <= 1'b0;
            wu_cnt            <= '0;
            idx               <= '0;
            wbank             <= 1'b0;
          end
          WARMUP: if (bus.sample_valid_in) begin
            wu_cnt <= wu_cnt + 1'b1;
            if (wu_cnt == WU_W'(WU_LAST)) state <= CAPTURE;
          end
          CAPTURE: if (bus.sample_valid_in) begin
            bus.buf_we_out    <= 1'b1;
            bus.buf_addr_out  <= {wbank, idx};
            bus.buf_wdata_out <= smp;
            if (idx == IDX_W'(FRAME_LEN - 1)) begin
              // claim lands next cycle so frame_ready trails the last write
              idx        <= '0;
              wbank      <= ~wbank;
              claim      <= 1'b1;
              claim_bank <= wbank;
              if (owned_eff[~wbank]) state <= DROP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          DROP: begin
            if (bus.sample_valid_in) bus.overflow_out <= 1'b1;
            if (!owned_eff[wbank]) state <= CAPTURE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      bus.dropped_count_out <= '0;
    end else if (bus.enable_in && state == IDLE) begin
      bus.dropped_count_out <= '0;
    end else if (bus.enable_in && state == DROP && bus.sample_valid_in &&
                 bus.dropped_count_out != 16'hFFFF) begin
      bus.dropped_count_out <= bus.dropped_count_out + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Directed bench for i2s_frame_scheduler with FRAME_LEN=4, WARMUP_SAMPLES=2.
module tb_i2s_frame_scheduler;
  localparam int GAP = 64;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  i2s_frame_scheduler_if #(.ADDR_W(3)) bus ();

  i2s_frame_scheduler #(.FRAME_LEN(4), .WARMUP_SAMPLES(2)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r, input logic done,
                      input logic exp_we, input logic [2:0] exp_addr, input string tag);
    repeat (GAP) @(negedge clk);
    bus.sample_valid_in = 1'b1;
    bus.left_sample_in  = l;
    bus.right_sample_in = r;
    bus.frame_done_in   = done;
    @(negedge clk);
    bus.sample_valid_in = 1'b0;
    bus.frame_done_in   = 1'b0;
    check({tag, "_we"}, 32'(bus.buf_we_out), 32'(exp_we));
    if (exp_we) begin
      check({tag, "_addr"}, 32'(bus.buf_addr_out), 32'(exp_addr));
      check({tag, "_data"}, bus.buf_wdata_out, {l, r});
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    bus.frame_done_in = 1'b1;
    @(negedge clk);
    bus.frame_done_in = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    bus.enable_in       = 1'b0;
    bus.sample_valid_in = 1'b0;
    bus.left_sample_in  = '0;
    bus.right_sample_in = '0;
    bus.frame_done_in   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_mic_reset", 32'(bus.mic_reset_out), 32'd1);
    check("rst_we",        32'(bus.buf_we_out), 32'd0);
    check("rst_addr",      32'(bus.buf_addr_out), 32'd0);
    check("rst_wdata",     bus.buf_wdata_out, 32'd0);
    check("rst_ready",     32'(bus.frame_ready_out), 32'd0);
    check("rst_bank",      32'(bus.frame_bank_out), 32'd0);
    check("rst_overflow",  32'(bus.overflow_out), 32'd0);
`ifdef FRAME_SCHED_STATS_EN
    check("rst_dropped",   32'(bus.dropped_count_out), 32'd0);
`endif

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_mic_reset", 32'(bus.mic_reset_out), 32'd1);
    bus.enable_in = 1'b1;
    @(negedge clk);
    check("en_mic_reset", 32'(bus.mic_reset_out), 32'd0);

    // warm-up then first frame in bank 0
    send(16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 3'd0, "warm0");
    send(16'hCAFE, 16'hF00D, 1'b0, 1'b0, 3'd0, "warm1");
    for (int i = 0; i < 4; i++)
      send(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0, 1'b1, 3'(i), "f0");
    check("f0_ready_early", 32'(bus.frame_ready_out), 32'd0);
    @(negedge clk);
    check("f0_ready", 32'(bus.frame_ready_out), 32'd1);
    check("f0_bank",  32'(bus.frame_bank_out), 32'd0);

    // second frame in bank 1, then release both in order
    for (int i = 0; i < 4; i++)
      send(16'h1100 + 16'(i), 16'h2100 + 16'(i), 1'b0, 1'b1, 3'(4 + i), "f1");
    @(negedge clk);
    check("f1_ready", 32'(bus.frame_ready_out), 32'd1);
    check("f1_bank",  32'(bus.frame_bank_out), 32'd0);
    pulse_done();
    check("rel0_ready", 32'(bus.frame_ready_out), 32'd1);
    check("rel0_bank",  32'(bus.frame_bank_out), 32'd1);
    pulse_done();
    check("rel1_ready", 32'(bus.frame_ready_out), 32'd0);
    check("rel1_overflow", 32'(bus.overflow_out), 32'd0);

    // overflow: two frames without release, then four dropped samples
    for (int i = 0; i < 8; i++)
      send(16'h3000 + 16'(i), 16'h4000 + 16'(i), 1'b0, 1'b1, 3'(i), "ov_fill");
    for (int i = 0; i < 4; i++)
      send(16'h3100 + 16'(i), 16'h4100 + 16'(i), 1'b0, 1'b0, 3'd0, "ov_drop");
    check("ov_overflow", 32'(bus.overflow_out), 32'd1);
`ifdef FRAME_SCHED_STATS_EN
    check("ov_dropped",  32'(bus.dropped_count_out), 32'd4);
`endif
    check("ov_bank", 32'(bus.frame_bank_out), 32'd0);
    pulse_done();
    check("ov_rel_ready", 32'(bus.frame_ready_out), 32'd1);
    check("ov_rel_bank",  32'(bus.frame_bank_out), 32'd1);
    send(16'hAAAA, 16'h5555, 1'b0, 1'b1, 3'd0, "ov_resume0");
    send(16'hAAAB, 16'h5556, 1'b0, 1'b1, 3'd1, "ov_resume1");

    // disable mid-frame
    @(negedge clk);
    bus.enable_in = 1'b0;
    @(negedge clk);
    check("dis_mic_reset", 32'(bus.mic_reset_out), 32'd1);
    check("dis_ready",     32'(bus.frame_ready_out), 32'd0);
    send(16'h7777, 16'h8888, 1'b0, 1'b0, 3'd0, "idle_sample");

    // re-enable: overflow cleared, stray done ignored, warm-up restarts
    bus.enable_in = 1'b1;
    @(negedge clk);
    check("reen_mic_reset", 32'(bus.mic_reset_out), 32'd0);
    check("reen_overflow",  32'(bus.overflow_out), 32'd0);
`ifdef FRAME_SCHED_STATS_EN
    check("reen_dropped",   32'(bus.dropped_count_out), 32'd0);
`endif
    pulse_done();
    check("stray_done_ready", 32'(bus.frame_ready_out), 32'd0);
    send(16'h0101, 16'h0202, 1'b0, 1'b0, 3'd0, "rwarm0");
    send(16'h0303, 16'h0404, 1'b0, 1'b0, 3'd0, "rwarm1");
    for (int i = 0; i < 4; i++)
      send(16'h5000 + 16'(i), 16'h6000 + 16'(i), 1'b0, 1'b1, 3'(i), "r0");
    @(negedge clk);
    check("r0_ready", 32'(bus.frame_ready_out), 32'd1);
    check("r0_bank",  32'(bus.frame_bank_out), 32'd0);

    // release coincides with completion of bank 1: no DROP follows
    for (int i = 0; i < 3; i++)
      send(16'h5100 + 16'(i), 16'h6100 + 16'(i), 1'b0, 1'b1, 3'(4 + i), "r1");
    send(16'h51FF, 16'h61FF, 1'b1, 1'b1, 3'd7, "r1_last");
    @(negedge clk);
    check("sim_ready", 32'(bus.frame_ready_out), 32'd1);
    check("sim_bank",  32'(bus.frame_bank_out), 32'd1);
    for (int i = 0; i < 3; i++)
      send(16'h5200 + 16'(i), 16'h6200 + 16'(i), 1'b0, 1'b1, 3'(i), "r2");
    check("sim_overflow", 32'(bus.overflow_out), 32'd0);

    // asynchronous reset while a write strobe is out
    repeat (GAP) @(negedge clk);
    bus.sample_valid_in = 1'b1;
    bus.left_sample_in  = 16'h9999;
    bus.right_sample_in = 16'h1111;
    @(posedge clk);
    #2;
    check("arst_pre_we",   32'(bus.buf_we_out), 32'd1);
    check("arst_pre_addr", 32'(bus.buf_addr_out), 32'd3);
    rst_n = 1'b0;
    #1;
    bus.sample_valid_in = 1'b0;
    check("arst_we",        32'(bus.buf_we_out), 32'd0);
    check("arst_addr",      32'(bus.buf_addr_out), 32'd0);
    check("arst_wdata",     bus.buf_wdata_out, 32'd0);
    check("arst_mic_reset", 32'(bus.mic_reset_out), 32'd1);
    check("arst_ready",     32'(bus.frame_ready_out), 32'd0);
    check("arst_bank",      32'(bus.frame_bank_out), 32'd0);
    check("arst_overflow",  32'(bus.overflow_out), 32'd0);
    repeat (2) @(negedge clk);
    check("arst_hold_we", 32'(bus.buf_we_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_frame_scheduler.md
# i2s_frame_scheduler

- Sequences the stereo I2S microphone capture path.
- Holds the I2S receiver in reset while disabled, then discards a warm-up interval of samples.
- Packs valid stereo samples into FRAME_LEN-sample frames in an external ping-pong buffer.
- Hands each completed frame to the downstream processing stage with a ready/done handshake, and flags overflow when that stage falls behind.

## Interface
- FRAME_LEN, 256: samples per frame; power of two, ≥ 2.
- WARMUP_SAMPLES, 4096: samples discarded after enable (≈63 ms at 65.1 kHz); 0 allowed.
- clock_in  input  1  100 MHz system clock.
- reset_n_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  level; 1 = capture running.
- mic_reset_out  output  1  active-high reset to the I2S receiver; 1 whenever the state is IDLE.
- sample_valid_in  input  1  one-cycle pulse from the receiver.
- left_sample_in  input  16  left sample; valid with the pulse.
- right_sample_in  input  16  right sample; valid with the pulse.
- buf_we_out  output  1  buffer write strobe.
- buf_addr_out  output  $clog2(FRAME_LEN)+1  MSB = bank, LSBs = sample index.
- buf_wdata_out  output  32  {left, right}.
- frame_ready_out  output  1  a completed frame is available.
- frame_bank_out  output  1  bank holding that frame; stable while frame_ready_out = 1.
- frame_done_in  input  1  one-cycle pulse; consumer releases bank frame_bank_out.
- overflow_out  output  1  sticky; at least one sample was dropped.

## Operation
- **States**
  - IDLE: mic_reset_out = 1.
  - WARMUP: discard samples.
  - CAPTURE: write samples to the write bank.
  - DROP: the write bank is still consumer-owned; samples are discarded.
- **Transitions**
  - IDLE→WARMUP when enable_in = 1. Warm-up counter cleared; write bank = 0; index = 0; both banks free; overflow_out cleared.
  - WARMUP→CAPTURE on the sample_valid_in that makes the discard count reach WARMUP_SAMPLES.
  - WARMUP→CAPTURE directly on entry if WARMUP_SAMPLES = 0.
  - Any state→IDLE when enable_in = 0, next cycle. The partial frame is abandoned, frame_ready_out drops and both banks are freed.
- **CAPTURE**
  - Each sample_valid_in writes {left,right} to {write_bank, index}, then increments the index.
  - On index FRAME_LEN-1:
    - the write bank is marked consumer-owned and queued for presentation;
    - the index wraps to 0 and the write bank toggles;
    - if the new write bank is still owned, go to DROP.
- **DROP**
  - Each sample_valid_in is discarded and sets overflow_out.
  - When the write bank is freed, return to CAPTURE with index 0. A frame always starts at index 0.
- **Presentation**
  - frame_ready_out = 1 while any owned bank is queued.
  - The oldest owned bank is presented first.
  - frame_done_in frees frame_bank_out. The other bank, if owned, is presented the next cycle.
- **Boundary rules**
  - frame_done_in with frame_ready_out = 0 is ignored.
  - frame_done_in in the same cycle as frame completion: the release is applied first, so the freed bank is writable and no DROP occurs.
  - sample_valid_in in the IDLE state is ignored.

## Timing
- Reset values: mic_reset_out = 1. buf_we_out, buf_addr_out, buf_wdata_out, frame_ready_out, frame_bank_out and overflow_out are all 0. State = IDLE.
- All outputs are registered.
- buf_we_out, buf_addr_out and buf_wdata_out are valid for the single cycle after sample_valid_in.
- frame_ready_out rises on the cycle after the last write of a frame (2 cycles after the final sample_valid_in).
- mic_reset_out falls 1 cycle after enable_in rises and rises 1 cycle after enable_in falls.
- Asynchronous reset during a write aborts it immediately; no further strobe is issued.
- Samples arrive ≥ 64 cycles apart, so no back-to-back handling is required.

## Configuration
- FRAME_SCHED_STATS_EN defined: adds output dropped_count_out [15:0].
  - Saturating count of samples discarded in DROP.
  - Cleared on reset and on IDLE→WARMUP.
  - Holds 16'hFFFF at saturation.
- Undefined: no port and no counter logic; overflow_out still present.

## Structure
- Package i2s_pkg holds:
  - SAMPLE_W = 16;
  - the sched_state_t enum {IDLE, WARMUP, CAPTURE, DROP};
  - the default FRAME_LEN and WARMUP_SAMPLES constants.
- Sub-module frame_bank_tracker holds the two ownership flags, the presentation-order bit, and the frame_ready_out/frame_bank_out logic.
  - Inputs: claim + bank, release.
  - Output: owned[1:0].
- The top level keeps the FSM, the counters and the buffer write port.

## Test plan
- **Warm-up and first frame**
  - FRAME_LEN = 4, WARMUP_SAMPLES = 2; enable, send 6 samples.
  - First 2 produce no writes.
  - Next 4 write addresses 0–3 with the correct {L,R}.
  - frame_ready_out = 1 with frame_bank_out = 0, 2 cycles after the 6th pulse.
- **Ping-pong and release**
  - Continue 4 samples (addresses 4–7), then pulse frame_done_in.
  - frame_bank_out switches to 1 the next cycle with frame_ready_out still 1.
- **Overflow**
  - Never assert frame_done_in; send 12 post-warm-up samples.
  - Last 4 samples produce no write and overflow_out = 1.
  - With FRAME_SCHED_STATS_EN, dropped_count_out = 4.
  - After frame_done_in, the next sample writes index 0 of the freed bank.
- **Simultaneous done and completion**
  - frame_done_in coincides with the cycle the second frame completes.
  - The third frame writes without DROP; overflow_out stays 0.
- **Disable and reset mid-frame**
  - Deassert enable_in after 2 samples: mic_reset_out = 1 and frame_ready_out = 0 next cycle.
  - Re-enable: warm-up restarts and the first write is to address 0.
  - Assert reset_n_in = 0 mid-capture: all outputs return to reset values immediately.
